// File: rtl/lab_mux_stream.sv
// lab_mux_stream: N-channel, WIDTH-bit selector with a registered valid/ready output stage.
// Define MUX_SCAN_EN to build the round-robin scan mode (FIXED/SCAN FSM plus pointer).
module lab_mux_stream #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 scan_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      xfer_cnt
);

  logic             accept;
  logic             chan_err;
  logic [SELW-1:0]  chan_c;
  logic [WIDTH-1:0] chan_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef MUX_SCAN_EN
  // state | meaning
  // FIXED | channel comes from sel
  // SCAN  | channel comes from ptr, which steps once per accepted transfer
  typedef enum logic {FIXED = 1'b0, SCAN = 1'b1} mode_t;

  mode_t           mode_q, mode_d;
  logic            scan_active;
  logic [SELW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= FIXED;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      FIXED:   if (scan_en)  mode_d = SCAN;
      SCAN:    if (!scan_en) mode_d = FIXED;
      default: mode_d = FIXED;
    endcase
  end

  always_comb begin
    scan_active = (mode_q == SCAN);
  end

  // The accept on the entry edge still uses FIXED; scanning starts from channel 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (mode_q == FIXED && mode_d == SCAN)
      ptr <= '0;
    else if (scan_active && accept)
      ptr <= (ptr == SELW'(N - 1)) ? '0 : ptr + 1'b1;
  end

  assign chan_c = scan_active ? ptr : sel;
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
  assign chan_c         = sel;
`endif

  // A select that matches no channel (only possible when N is not a power of two) flags an error.
  always_comb begin
    chan_data = '0;
    chan_err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (chan_c == SELW'(i)) begin
        chan_data = in_data[i*WIDTH +: WIDTH];
        chan_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= chan_data;
      out_chan  <= chan_c;
      out_err   <= chan_err;
      xfer_cnt  <= xfer_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lab_mux_stream.sv
// Bench for lab_mux_stream: a 4-channel/16-bit-counter instance and a 3-channel/4-bit-counter
// instance share one stimulus stream; a scoreboard checks every consumed output of both.
module tb_lab_mux_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = 32'h4433_2211;
  logic [1:0]  sel = 2'd2;
  logic        scan_en = 1'b0;
  logic        in_valid = 1'b1;
  logic        out_ready = 1'b0;

  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_err_a, out_err_b;
  logic [7:0]  out_data_a, out_data_b;
  logic [1:0]  out_chan_a, out_chan_b;
  logic [15:0] xfer_cnt_a;
  logic [3:0]  xfer_cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  d;
    logic [1:0]  ch;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  lab_mux_stream #(.N(4), .WIDTH(8), .CNTW(16)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .scan_en(scan_en),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a), .out_chan(out_chan_a),
    .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready), .xfer_cnt(xfer_cnt_a)
  );

  lab_mux_stream #(.N(3), .WIDTH(8), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data[23:0]), .sel(sel), .scan_en(scan_en),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b), .out_chan(out_chan_b),
    .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready), .xfer_cnt(xfer_cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced at each falling edge from the inputs the next rising edge will see
  logic        m_valid = 1'b0;
  logic        m_scan = 1'b0;
  logic        acc;
  logic [1:0]  pa = 2'd0, pb = 2'd0, ca, cb;
  logic [15:0] ma_cnt = 16'd0;
  logic [3:0]  mb_cnt = 4'd0;
  exp_t        ea, eb;

  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      qb.delete();
      m_valid = 1'b0;
      m_scan  = 1'b0;
      pa = 2'd0;
      pb = 2'd0;
      ma_cnt = 16'd0;
      mb_cnt = 4'd0;
    end else begin
      chk("in_ready_a", in_ready_a, !m_valid || out_ready);
      chk("in_ready_b", in_ready_b, !m_valid || out_ready);
      chk("out_valid_a", out_valid_a, m_valid);
      chk("out_valid_b", out_valid_b, m_valid);
      if (m_valid && out_ready) begin
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("sb_a_data", out_data_a, ea.d);
          chk("sb_a_chan", out_chan_a, ea.ch);
          chk("sb_a_err", out_err_a, ea.err);
          chk("sb_a_cnt", xfer_cnt_a, ea.cnt);
        end
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("sb_b_data", out_data_b, eb.d);
          chk("sb_b_chan", out_chan_b, eb.ch);
          chk("sb_b_err", out_err_b, eb.err);
          chk("sb_b_cnt", xfer_cnt_b, eb.cnt[3:0]);
        end
      end
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        ca = m_scan ? pa : sel;
        cb = m_scan ? pb : sel;
        ma_cnt = ma_cnt + 16'd1;
        mb_cnt = mb_cnt + 4'd1;
        ea.d = in_data[ca*8 +: 8];
        ea.ch = ca;
        ea.err = 1'b0;
        ea.cnt = ma_cnt;
        eb.d = (cb < 2'd3) ? in_data[cb*8 +: 8] : 8'h00;
        eb.ch = cb;
        eb.err = (cb == 2'd3);
        eb.cnt = {12'd0, mb_cnt};
        qa.push_back(ea);
        qb.push_back(eb);
      end
`ifdef MUX_SCAN_EN
      if (!m_scan && scan_en) begin
        pa = 2'd0;
        pb = 2'd0;
      end else if (m_scan && acc) begin
        pa = (pa == 2'd3) ? 2'd0 : pa + 2'd1;
        pb = (pb == 2'd2) ? 2'd0 : pb + 2'd1;
      end
      m_scan = scan_en;
`endif
      if (acc) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t3_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
  logic [1:0] t3_sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] t5_sel  [5] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
`ifdef MUX_SCAN_EN
  logic [1:0] t5_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
  logic [1:0] t5_chan [5] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
`endif

  initial begin
    // Reset holds everything idle even with a request pending
    repeat (3) step();
    chk("rst_valid_a", out_valid_a, 1'b0);
    chk("rst_cnt_a", xfer_cnt_a, 16'd0);
    chk("rst_cnt_b", xfer_cnt_b, 4'd0);
    reset = 1'b0;
    step();
    chk("t1_data", out_data_a, 8'h33);
    chk("t1_chan", out_chan_a, 2'd2);
    chk("t1_valid", out_valid_a, 1'b1);

    // Backpressure: second request stalls until the consumer is ready
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    sel = 2'd1;
    in_valid = 1'b1;
    step();
    chk("t2_first_data", out_data_a, 8'h22);
    sel = 2'd3;
    #1;
    chk("t2_stall_ready", in_ready_a, 1'b0);
    step();
    chk("t2_hold_data", out_data_a, 8'h22);
    chk("t2_hold_chan", out_chan_a, 2'd1);
    chk("t2_hold_cnt", xfer_cnt_a, 16'd1);
    out_ready = 1'b1;
    #1;
    chk("t2_ready_up", in_ready_a, 1'b1);
    step();
    chk("t2_data", out_data_a, 8'h44);
    chk("t2_cnt", xfer_cnt_a, 16'd2);
    // Same transfer on the 3-channel instance selects a missing channel
    chk("t4_data", out_data_b, 8'h00);
    chk("t4_err", out_err_b, 1'b1);
    chk("t4_chan", out_chan_b, 2'd3);
    chk("t4_cnt", xfer_cnt_b, 4'd2);

    // Full throughput
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel = t3_sel[i];
      step();
      chk("t3_valid", out_valid_a, 1'b1);
      chk("t3_data", out_data_a, t3_data[i]);
    end
    chk("t3_cnt", xfer_cnt_a, 16'd6);

    // Scan request: the entry edge still uses sel
    scan_en = 1'b1;
    sel = 2'd2;
    step();
    chk("t5_entry_chan", out_chan_a, 2'd2);
    for (int i = 0; i < 5; i++) begin
      sel = t5_sel[i];
      step();
      chk("t5_chan", out_chan_a, t5_chan[i]);
    end
    scan_en = 1'b0;
    step();
    step();

    // Counter wrap on the 4-bit instance, then reset mid-stream
    reset = 1'b1;
    step();
    reset = 1'b0;
    sel = 2'd0;
    repeat (17) step();
    chk("t6_cnt_b", xfer_cnt_b, 4'd1);
    chk("t6_cnt_a", xfer_cnt_a, 16'd17);
    chk("t6_valid_pre", out_valid_a, 1'b1);
    reset = 1'b1;
    step();
    chk("t6_valid_a", out_valid_a, 1'b0);
    chk("t6_valid_b", out_valid_b, 1'b0);
    chk("t6_cnt_rst", xfer_cnt_a, 16'd0);
    reset = 1'b0;
    scan_en = 1'b1;
    sel = 2'd3;
    step();
    step();
    chk("t6_ptr_rst", out_chan_a, t5_chan[0]);
    in_valid = 1'b0;
    scan_en = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
